// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle control FSM that steps the datapath through fetch, decode,
// operand fetch, execute, data-memory access and write-back, one phase per state.
// Optional feature: define SEQ_PERF_CNT_EN to build the busy-cycle and retired-instruction
// counters; otherwise cycle_cnt_o and retired_cnt_o are tied to zero.
module datapath_sequencer #(
  parameter int unsigned MemTimeout = 15,  // max ready wait cycles before fault, 0 = no limit
  parameter int unsigned CntW       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            is_ld_i,
  input  logic            is_st_i,
  input  logic            is_call_i,
  input  logic            is_ret_i,
  input  logic            is_wb_i,
  input  logic            is_branch_i,
  input  logic            is_halt_i,
  input  logic            imem_ready_i,
  input  logic            dmem_ready_i,
  output logic            imem_req_o,
  output logic            dmem_rd_o,
  output logic            dmem_wr_o,
  output logic            ld_ir_o,
  output logic            ld_pc_o,
  output logic [1:0]      pc_src_o,
  output logic            clr_data_o,
  output logic            ld_data_o,
  output logic            ld_alu_o,
  output logic            wr_o,
  output logic [2:0]      state_o,
  output logic            busy_o,
  output logic            fault_o,
  output logic [CntW-1:0] cycle_cnt_o,
  output logic [CntW-1:0] retired_cnt_o
);

  localparam int unsigned WaitW = (MemTimeout > 0) ? $clog2(MemTimeout + 1) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StOpfetch = 3'd3,
    StExec    = 3'd4,
    StMem     = 3'd5,
    StWb      = 3'd6,
    StFault   = 3'd7
  } state_e;

  // Halt is acted on in decode itself, so it is not kept past that state.
  typedef struct packed {
    logic ld;
    logic st;
    logic call;
    logic ret;
    logic wb;
    logic branch;
  } flags_t;

  state_e           state_q, state_d;
  flags_t           flags_q, flags_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_hit;
  logic             decode_bad;
  logic             retire;
  state_e           retire_state;

  // The wait that would take the count to the limit is the expiring one.
  assign timeout_hit  = (MemTimeout != 0) && ((32'(wait_q) + 32'd1) >= MemTimeout);
  assign decode_bad   = (is_ld_i & is_st_i) | (is_call_i & is_ret_i);
  assign retire_state = run_i ? StFetch : StIdle;

  // State, latched decoder flags and memory wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      flags_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; ready is checked before timeout so a late ready still wins.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    wait_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready_i) begin
          state_d = StDecode;
        end else begin
          wait_d = wait_q + WaitW'(1);
          if (timeout_hit) state_d = StFault;
        end
      end
      StDecode: begin
        flags_d = '{ld: is_ld_i, st: is_st_i, call: is_call_i, ret: is_ret_i,
                    wb: is_wb_i, branch: is_branch_i};
        if (decode_bad)     state_d = StFault;
        else if (is_halt_i) state_d = StIdle;
        else                state_d = StOpfetch;
      end
      StOpfetch: state_d = StExec;
      StExec: begin
        if (flags_q.ld || flags_q.st)        state_d = StMem;
        else if (flags_q.wb || flags_q.call) state_d = StWb;
        else                                 state_d = retire_state;
      end
      StMem: begin
        if (dmem_ready_i) begin
          state_d = flags_q.ld ? StWb : retire_state;
        end else begin
          wait_d = wait_q + WaitW'(1);
          if (timeout_hit) state_d = StFault;
        end
      end
      StWb:    state_d = retire_state;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  // Control outputs decoded from state, latched flags and the ready handshakes.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_rd_o  = 1'b0;
    dmem_wr_o  = 1'b0;
    ld_ir_o    = 1'b0;
    clr_data_o = 1'b0;
    ld_data_o  = 1'b0;
    ld_alu_o   = 1'b0;
    wr_o       = 1'b0;
    retire     = 1'b0;
    pc_src_o   = 2'd0;
    unique case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        ld_ir_o    = imem_ready_i;
      end
      StDecode:  clr_data_o = 1'b1;
      StOpfetch: ld_data_o  = 1'b1;
      StExec: begin
        ld_alu_o = 1'b1;
        retire   = ~(flags_q.ld | flags_q.st | flags_q.wb | flags_q.call);
      end
      StMem: begin
        dmem_rd_o = flags_q.ld;
        dmem_wr_o = flags_q.st;
        retire    = dmem_ready_i & ~flags_q.ld;
      end
      StWb: begin
        wr_o   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    if (retire) begin
      if (flags_q.ret)                       pc_src_o = 2'd2;
      else if (flags_q.branch | flags_q.call) pc_src_o = 2'd1;
      else                                    pc_src_o = 2'd0;
    end
  end

  assign ld_pc_o = retire;
  assign state_o = state_q;
  assign busy_o  = (state_q != StIdle) && (state_q != StFault);
  assign fault_o = (state_q == StFault);

`ifdef SEQ_PERF_CNT_EN
  logic [CntW-1:0] cycle_cnt_q, retired_cnt_q;

  // Busy-cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (busy_o) cycle_cnt_q   <= cycle_cnt_q + CntW'(1);
      if (retire) retired_cnt_q <= retired_cnt_q + CntW'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`else
  assign cycle_cnt_o   = '0;
  assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: randomized and directed instruction sequences checked against a
// per-instruction phase model (latency, pulse positions, memory handshakes, PC select).
module tb_datapath_sequencer;

  localparam int unsigned MemTo = 15;
  localparam int unsigned CntW  = 32;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam int FLd = 0, FSt = 1, FCall = 2, FRet = 3, FWb = 4, FBr = 5, FHalt = 6;
  localparam logic [6:0] KLd = 7'h01, KSt = 7'h02, KCall = 7'h04, KRet = 7'h08;
  localparam logic [6:0] KWb = 7'h10, KBr = 7'h20;

  logic clk_i = 1'b0;
  logic rst_ni, run_i;
  logic is_ld_i, is_st_i, is_call_i, is_ret_i, is_wb_i, is_branch_i, is_halt_i;
  logic imem_ready_i, dmem_ready_i;
  logic imem_req_o, dmem_rd_o, dmem_wr_o, ld_ir_o, ld_pc_o;
  logic [1:0] pc_src_o;
  logic clr_data_o, ld_data_o, ld_alu_o, wr_o;
  logic [2:0] state_o;
  logic busy_o, fault_o;
  logic [CntW-1:0] cycle_cnt_o, retired_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  longint exp_cycles, exp_retired;

  datapath_sequencer #(.MemTimeout(MemTo), .CntW(CntW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i),
    .is_ld_i(is_ld_i), .is_st_i(is_st_i), .is_call_i(is_call_i), .is_ret_i(is_ret_i),
    .is_wb_i(is_wb_i), .is_branch_i(is_branch_i), .is_halt_i(is_halt_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .dmem_rd_o(dmem_rd_o), .dmem_wr_o(dmem_wr_o),
    .ld_ir_o(ld_ir_o), .ld_pc_o(ld_pc_o), .pc_src_o(pc_src_o),
    .clr_data_o(clr_data_o), .ld_data_o(ld_data_o), .ld_alu_o(ld_alu_o), .wr_o(wr_o),
    .state_o(state_o), .busy_o(busy_o), .fault_o(fault_o),
    .cycle_cnt_o(cycle_cnt_o), .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_flags(input logic [6:0] f);
    is_ld_i = f[FLd]; is_st_i = f[FSt]; is_call_i = f[FCall]; is_ret_i = f[FRet];
    is_wb_i = f[FWb]; is_branch_i = f[FBr]; is_halt_i = f[FHalt];
  endtask

  // Instruction-level model: phase count and visible effects from the decoded flags.
  function automatic void model(input logic [6:0] f, input int iw, input int dw,
                                input bit run_v, output int outcome, output int lat,
                                output int wr_n, output int rd_n, output int wm_n,
                                output int pcs, output int end_st);
    bit mem, wb;
    outcome = 0; lat = 0; wr_n = 0; rd_n = 0; wm_n = 0; pcs = 0; end_st = 0;
    if ((f[FLd] && f[FSt]) || (f[FCall] && f[FRet])) begin
      outcome = 2; lat = iw + 2; end_st = 7;
    end else if (f[FHalt]) begin
      outcome = 1; lat = iw + 2; end_st = 0;
    end else begin
      mem  = f[FLd] || f[FSt];
      wb   = f[FLd] || (!mem && (f[FWb] || f[FCall]));
      // fetch (with waits) + decode + operand fetch + execute + optional mem and write-back
      lat  = (iw + 1) + 3 + (mem ? dw + 1 : 0) + (wb ? 1 : 0);
      rd_n = f[FLd] ? dw + 1 : 0;
      wm_n = f[FSt] ? dw + 1 : 0;
      wr_n = wb ? 1 : 0;
      pcs  = f[FRet] ? 2 : ((f[FBr] || f[FCall]) ? 1 : 0);
      end_st = run_v ? 1 : 0;
    end
  endfunction

  task automatic do_reset();
    #1 rst_ni = 1'b0;
    run_i = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0; set_flags(7'h00);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    exp_cycles = 0; exp_retired = 0;
  endtask

  // Runs one instruction from FETCH with reactive memories and compares it to the model.
  task automatic exec_and_check(input string name, input logic [6:0] f, input int iw,
                                input int dw, input bit run_v);
    int e_out, e_lat, e_wr, e_rd, e_wm, e_pcs, e_end;
    int icnt, dcnt, cyc, c_ir, c_clr, c_ldd, c_alu, c_wr, c_pc, n_wr, n_pc, n_rd, n_wm;
    int obs_pcs;
    bit done, ret_now;
    model(f, iw, dw, run_v, e_out, e_lat, e_wr, e_rd, e_wm, e_pcs, e_end);
    if (state_o == 3'd0) begin
      run_i = 1'b1;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (state_o !== 3'd1) begin
      $display("FAIL %s start_state: got %0d want 1", name, state_o);
      return;
    end
    n_pass++;
    icnt = 0; dcnt = 0; cyc = 0; done = 0; obs_pcs = 0;
    c_ir = 0; c_clr = 0; c_ldd = 0; c_alu = 0; c_wr = 0; c_pc = 0;
    n_wr = 0; n_pc = 0; n_rd = 0; n_wm = 0;
    while (!done && cyc < 80) begin
      cyc++;
      run_i        = run_v;
      imem_ready_i = imem_req_o ? (icnt >= iw) : 1'($urandom);
      dmem_ready_i = (dmem_rd_o || dmem_wr_o) ? (dcnt >= dw) : 1'($urandom);
      if (cyc == iw + 2) set_flags(f);
      else               set_flags(7'($urandom));
      @(negedge clk_i);
      if (ld_ir_o    && c_ir  == 0) c_ir  = cyc;
      if (clr_data_o && c_clr == 0) c_clr = cyc;
      if (ld_data_o  && c_ldd == 0) c_ldd = cyc;
      if (ld_alu_o   && c_alu == 0) c_alu = cyc;
      if (wr_o)    begin c_wr = cyc; n_wr++; end
      if (ld_pc_o) begin c_pc = cyc; n_pc++; obs_pcs = int'(pc_src_o); end
      if (dmem_rd_o) n_rd++;
      if (dmem_wr_o) n_wm++;
      if (imem_req_o) icnt++;
      if (dmem_rd_o || dmem_wr_o) dcnt++;
      ret_now = ld_pc_o;
      @(posedge clk_i); #1;
      if (ret_now || state_o == 3'd0 || state_o == 3'd7) done = 1;
    end
    n_checks++; if (cyc !== e_lat) $display("FAIL %s latency: got %0d want %0d", name, cyc, e_lat);
    else n_pass++;
    n_checks++; if (int'(state_o) !== e_end)
      $display("FAIL %s end_state: got %0d want %0d", name, state_o, e_end); else n_pass++;
    n_checks++; if (c_ir !== iw + 1)
      $display("FAIL %s ldIR_cycle: got %0d want %0d", name, c_ir, iw + 1); else n_pass++;
    n_checks++; if (c_clr !== iw + 2)
      $display("FAIL %s clrData_cycle: got %0d want %0d", name, c_clr, iw + 2); else n_pass++;
    n_checks++; if (c_ldd !== (e_out == 0 ? iw + 3 : 0))
      $display("FAIL %s ldData_cycle: got %0d want %0d", name, c_ldd, e_out == 0 ? iw + 3 : 0);
    else n_pass++;
    n_checks++; if (c_alu !== (e_out == 0 ? iw + 4 : 0))
      $display("FAIL %s ldAlu_cycle: got %0d want %0d", name, c_alu, e_out == 0 ? iw + 4 : 0);
    else n_pass++;
    n_checks++; if (n_wr !== e_wr || c_wr !== (e_wr != 0 ? e_lat : 0))
      $display("FAIL %s wr: got count %0d at %0d want count %0d at %0d", name, n_wr, c_wr, e_wr,
               e_wr != 0 ? e_lat : 0); else n_pass++;
    n_checks++; if (n_pc !== (e_out == 0 ? 1 : 0) || c_pc !== (e_out == 0 ? e_lat : 0))
      $display("FAIL %s ldPC: got count %0d at %0d want count %0d at %0d", name, n_pc, c_pc,
               e_out == 0 ? 1 : 0, e_out == 0 ? e_lat : 0); else n_pass++;
    n_checks++; if (obs_pcs !== e_pcs)
      $display("FAIL %s pcSrc: got %0d want %0d", name, obs_pcs, e_pcs); else n_pass++;
    n_checks++; if (n_rd !== e_rd || n_wm !== e_wm)
      $display("FAIL %s dmem_req: got rd %0d wr %0d want rd %0d wr %0d", name, n_rd, n_wm,
               e_rd, e_wm); else n_pass++;
    exp_cycles  += e_lat;
    exp_retired += (e_out == 0) ? 1 : 0;
  endtask

  task automatic check_counters(input string name);
    longint ec, er;
    ec = PerfEn ? exp_cycles : 0;
    er = PerfEn ? exp_retired : 0;
    n_checks++;
    if (longint'(cycle_cnt_o) !== ec || longint'(retired_cnt_o) !== er)
      $display("FAIL %s counters: got cycles %0d retired %0d want cycles %0d retired %0d",
               name, cycle_cnt_o, retired_cnt_o, ec, er);
    else n_pass++;
  endtask

  task automatic test_reset();
    int k;
    rst_ni = 1'b0; run_i = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0; set_flags(7'h00);
    #12;
    n_checks++;
    if ({imem_req_o, dmem_rd_o, dmem_wr_o, ld_ir_o, ld_pc_o, pc_src_o, clr_data_o, ld_data_o,
         ld_alu_o, wr_o, state_o, busy_o, fault_o} !== 16'h0 || cycle_cnt_o !== '0 ||
        retired_cnt_o !== '0)
      $display("FAIL reset_outputs: got state %0d busy %0b fault %0b imem_req %0b", state_o,
               busy_o, fault_o, imem_req_o);
    else n_pass++;
    @(negedge clk_i) rst_ni = 1'b1;
    run_i = 1'b1; imem_ready_i = 1'b1; set_flags(KWb);
    k = 0;
    @(posedge clk_i); #1;
    while (state_o != 3'd4 && k < 10) begin @(posedge clk_i); #1; k++; end
    n_checks++; if (state_o !== 3'd4) $display("FAIL reach_exec: got %0d want 4", state_o);
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 3'd0 || wr_o !== 1'b0 || ld_pc_o !== 1'b0 || ld_alu_o !== 1'b0)
      $display("FAIL reset_mid_exec: got state %0d wr %0b ldPC %0b ldAlu %0b want 0 0 0 0",
               state_o, wr_o, ld_pc_o, ld_alu_o);
    else n_pass++;
    n_checks++;
    if (cycle_cnt_o !== '0 || retired_cnt_o !== '0)
      $display("FAIL reset_counters: got %0d %0d want 0 0", cycle_cnt_o, retired_cnt_o);
    else n_pass++;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (imem_req_o !== 1'b1 || state_o !== 3'd1)
      $display("FAIL release_fetch: got imem_req %0b state %0d want 1 1", imem_req_o, state_o);
    else n_pass++;
  endtask

  task automatic test_alu_wb();
    do_reset();
    exec_and_check("alu_wb", KWb, 0, 0, 1'b1);
    check_counters("alu_wb");
  endtask

  task automatic test_load_wait();
    do_reset();
    exec_and_check("load_wait3", KLd, 0, 3, 1'b1);
    exec_and_check("store_nowait", KSt | KWb, 0, 0, 1'b1);
    exec_and_check("load_ready_at_expiry", KLd, 2, 14, 1'b1);
    exec_and_check("fetch_ready_at_expiry", KBr, 14, 0, 1'b1);
    check_counters("load_wait");
  endtask

  task automatic test_ret_call();
    do_reset();
    exec_and_check("ret", KRet, 0, 0, 1'b1);
    exec_and_check("call", KCall, 0, 0, 1'b1);
    exec_and_check("branch", KBr, 1, 0, 1'b1);
    exec_and_check("halt", 7'h40, 0, 0, 1'b1);
    check_counters("ret_call");
  endtask

  task automatic test_run_stop();
    do_reset();
    exec_and_check("store_run_low", KSt, 0, 1, 1'b0);
    @(posedge clk_i); #1;
    n_checks++;
    if (state_o !== 3'd0 || imem_req_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL stay_idle: got state %0d imem_req %0b busy %0b", state_o, imem_req_o,
               busy_o);
    else n_pass++;
  endtask

  task automatic test_decode_fault();
    do_reset();
    exec_and_check("ld_st_fault", KLd | KSt, 0, 0, 1'b1);
    n_checks++; if (fault_o !== 1'b1) $display("FAIL ldst_fault_flag: got %0b want 1", fault_o);
    else n_pass++;
    do_reset();
    exec_and_check("call_ret_fault", KCall | KRet | KWb, 2, 0, 1'b1);
  endtask

  task automatic test_timeout();
    int cnt, k;
    do_reset();
    run_i = 1'b1; imem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    cnt = 0;
    while (state_o == 3'd1 && cnt < 40) begin
      @(negedge clk_i); if (imem_req_o) cnt++;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (cnt !== 15 || state_o !== 3'd7)
      $display("FAIL imem_timeout: got %0d waits state %0d want 15 waits state 7", cnt, state_o);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      run_i = ~run_i; imem_ready_i = 1'($urandom); dmem_ready_i = 1'($urandom);
      set_flags(7'($urandom));
      @(posedge clk_i); #1;
      n_checks++;
      if (fault_o !== 1'b1 || state_o !== 3'd7 || busy_o !== 1'b0 || imem_req_o !== 1'b0)
        $display("FAIL fault_sticky: got fault %0b state %0d busy %0b imem_req %0b", fault_o,
                 state_o, busy_o, imem_req_o);
      else n_pass++;
    end
    do_reset();
    run_i = 1'b1; imem_ready_i = 1'b1; dmem_ready_i = 1'b0; set_flags(KLd);
    k = 0;
    while (state_o != 3'd5 && k < 10) begin @(posedge clk_i); #1; k++; end
    cnt = 0;
    while (state_o == 3'd5 && cnt < 40) begin
      @(negedge clk_i); if (dmem_rd_o) cnt++;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (cnt !== 15 || state_o !== 3'd7)
      $display("FAIL dmem_timeout: got %0d waits state %0d want 15 waits state 7", cnt, state_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] f;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      f = 7'($urandom);
      if (f[FLd] && f[FSt])    f[FSt] = 1'b0;
      if (f[FCall] && f[FRet]) f[FRet] = 1'b0;
      f[FHalt] = ($urandom_range(0, 7) == 0);
      exec_and_check($sformatf("rand%0d", i), f, $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 5) != 0);
    end
    check_counters("back_to_back");
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load_wait();
    test_ret_call();
    test_run_stop();
    test_decode_fault();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multi-cycle control FSM that sequences the processor datapath: instruction fetch, decode, operand fetch from the register file, execute, data-memory access and register write-back. It drives the register-file operand-latch controls (ldData/clrData) and write enable (wr), the instruction/data memory request handshakes, and the PC load/select. It sits between the instruction decoder, whose flags it consumes, and the register file, ALU and memories, which it steps one phase per state.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max wait cycles for imem_ready/dmem_ready before FAULT; 0 disables timeout.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  1 = execute; 0 = stop at next instruction boundary.
- isLd, isSt, isCall, isRet, isWb, isBranch, isHalt  in  1 each  decoder flags, valid in DECODE.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- dmem_rd, dmem_wr  out  1 each  data memory read/write request.
- ldIR  out  1  load instruction register.
- ldPC  out  1  load PC.
- pcSrc  out  2  0 = PC+4, 1 = branch/call target, 2 = r15 (return).
- clrData  out  1  clear register-file operand latches.
- ldData  out  1  load register-file operand latches.
- ldAlu  out  1  capture ALU result.
- wr  out  1  register-file write enable.
- state  out  3  current state encoding.
- busy  out  1  state not IDLE and not FAULT.
- fault  out  1  sticky fault flag.
- cycle_cnt, retired_cnt  out  CNT_W each  performance counters.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, OPFETCH=3, EXEC=4, MEM=5, WB=6, FAULT=7.
- IDLE: all controls 0; run=1 -> FETCH.
- FETCH: imem_req=1 held; on imem_ready: ldIR=1 same cycle, -> DECODE.
- DECODE: clrData=1; latch all decoder flags into internal regs. isLd&isSt or isCall&isRet -> FAULT. isHalt -> IDLE (no retire). Else -> OPFETCH.
- OPFETCH: ldData=1 -> EXEC.
- EXEC: ldAlu=1. Latched isLd|isSt -> MEM; else isWb|isCall -> WB; else retire.
- MEM: dmem_rd=isLd or dmem_wr=isSt, held until dmem_ready. On ready: isLd -> WB; isSt -> retire.
- WB: wr=1 one cycle; retire.
- Retire (last cycle of instruction): ldPC=1; pcSrc=2 if isRet, 1 if isBranch|isCall, else 0; next state FETCH if run=1 else IDLE.
- Timeout: wait counter cleared on entry to FETCH/MEM, increments each cycle ready is low; reaching MEM_TIMEOUT -> FAULT.
- FAULT: all controls 0, fault=1; left only by reset.
- Outputs decoded combinationally from state and latched flags; ldIR, ldPC and the MEM exit additionally depend on ready inputs.

## Timing
- Reset: state=IDLE, all outputs 0, counters 0, latched flags 0; applies immediately, mid-instruction included (no wr/ldPC completes).
- Latency with zero-wait memory: branch/ret without write-back 4 cycles; ALU with write-back or call 5; store 5; load 6.
- run deasserted mid-instruction: instruction completes and retires, then IDLE.
- Ready arriving in the same cycle as timeout expiry: ready wins.
- Flags outside DECODE ignored.

## Configuration
- SEQ_PERF_CNT_EN defined: cycle_cnt increments every cycle busy=1; retired_cnt increments on each retire; both wrap modulo 2^CNT_W.
- Undefined: counter logic absent, cycle_cnt and retired_cnt tied 0.

## Test plan
- Reset low mid-EXEC -> state=0, wr=0, ldPC=0 immediately; release with run=1 -> imem_req=1 next cycle.
- ALU op isWb=1, zero-wait memory -> ldIR, clrData, ldData, ldAlu, wr on cycles 1..5 consecutively, ldPC with wr, pcSrc=0, retired_cnt=1.
- Load with dmem_ready after 3 cycles -> dmem_rd held 4 cycles, then wr=1, total 9 cycles.
- isRet=1 -> ldPC=1, pcSrc=2 in EXEC, no wr; isCall=1 -> wr=1, pcSrc=1 in WB.
- imem_ready held low, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, fault=1 sticky while run toggles.
- isLd=isSt=1 in DECODE -> FAULT next cycle; run=0 during store -> store retires, then IDLE.
